// File: rtl/term_accumulator_pkg.sv
// Shared types and sizing constants for the postfix term accumulator and its operand stack.
package term_accumulator_pkg;

    localparam int unsigned TERM_DATA_WIDTH  = 32;
    localparam int unsigned TERM_STACK_DEPTH = 16;

    typedef logic [TERM_DATA_WIDTH-1:0] term_word_t;

endpackage

// File: rtl/term_operand_stack.sv
// LIFO operand stack: registered top-of-stack plus a lower-entry array, with
// occupancy flags and sticky overflow/underflow error flags.
module term_operand_stack
    import term_accumulator_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = TERM_DATA_WIDTH,
    parameter int unsigned DEPTH      = TERM_STACK_DEPTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         stack_clear,
    input  logic                         stack_push,
    input  logic                         stack_pop,
    input  logic [DATA_WIDTH-1:0]        stack_input,
    output logic [DATA_WIDTH-1:0]        stack_output,
    output logic [$clog2(DEPTH+1)-1:0]   stack_count,
    output logic                         stack_empty,
    output logic                         stack_full,
    output logic                         stack_overflow,
    output logic                         stack_underflow
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;

    logic [DATA_WIDTH-1:0] top_q;
    logic [DATA_WIDTH-1:0] lower_mem [DEPTH-1];
    logic [CW-1:0]         count_q;
    logic                  overflow_q;
    logic                  underflow_q;

    logic                  is_empty;
    logic                  is_full;
    logic [AW-1:0]         spill_idx;
    logic [AW-1:0]         reload_idx;
    logic                  spill;

    assign is_empty   = (count_q == '0);
    assign is_full    = (count_q == CW'(DEPTH));
    assign spill_idx  = AW'(count_q - CW'(1));
    assign reload_idx = AW'(count_q - CW'(2));

    // Old top moves into the array only on a plain push onto a non-empty, non-full stack.
    assign spill = !reset && !stack_clear && stack_push && !stack_pop && !is_empty && !is_full;

    always_ff @(posedge clock) begin
        if (spill) begin
            lower_mem[spill_idx] <= top_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || stack_clear) begin
            top_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            unique case ({stack_push, stack_pop})
                2'b10: begin
                    if (is_full) begin
                        overflow_q <= 1'b1;
                    end else begin
                        top_q   <= stack_input;
                        count_q <= count_q + CW'(1);
                    end
                end
                2'b01: begin
                    if (is_empty) begin
                        underflow_q <= 1'b1;
                    end else begin
                        count_q <= count_q - CW'(1);
                        top_q   <= (count_q >= CW'(2)) ? lower_mem[reload_idx] : '0;
                    end
                end
                2'b11: begin
                    // Replace-top; on an empty stack the pop half faults but the push still lands.
                    top_q <= stack_input;
                    if (is_empty) begin
                        underflow_q <= 1'b1;
                        count_q     <= CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign stack_output    = top_q;
    assign stack_count     = count_q;
    assign stack_empty     = is_empty;
    assign stack_full      = is_full;
    assign stack_overflow  = overflow_q;
    assign stack_underflow = underflow_q;

endmodule

// File: tb/tb_term_operand_stack.sv
// Bench for term_operand_stack: queue-based reference model checked every cycle,
// plus directed sequences with literal expectations.
module tb_term_operand_stack;
    import term_accumulator_pkg::*;

    localparam int unsigned DEPTH = TERM_STACK_DEPTH;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic             clock = 1'b0;
    logic             reset;
    logic             stack_clear;
    logic             stack_push;
    logic             stack_pop;
    term_word_t       stack_input;
    term_word_t       stack_output;
    logic [CW-1:0]    stack_count;
    logic             stack_empty;
    logic             stack_full;
    logic             stack_overflow;
    logic             stack_underflow;

    int n_cmp = 0;
    int n_bad = 0;

    term_word_t mq[$];
    bit         m_ovf;
    bit         m_unf;
    bit         chk_en = 1'b0;

    term_operand_stack #(
        .DATA_WIDTH(TERM_DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .stack_clear    (stack_clear),
        .stack_push     (stack_push),
        .stack_pop      (stack_pop),
        .stack_input    (stack_input),
        .stack_output   (stack_output),
        .stack_count    (stack_count),
        .stack_empty    (stack_empty),
        .stack_full     (stack_full),
        .stack_overflow (stack_overflow),
        .stack_underflow(stack_underflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: a plain queue whose last element is the top of stack.
    always @(posedge clock) begin
        if (reset || stack_clear) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            chk_en = 1'b1;
        end else if (stack_push && stack_pop) begin
            if (mq.size() == 0) begin
                m_unf = 1'b1;
                mq.push_back(stack_input);
            end else begin
                mq[mq.size()-1] = stack_input;
            end
        end else if (stack_push) begin
            if (mq.size() == DEPTH) m_ovf = 1'b1;
            else mq.push_back(stack_input);
        end else if (stack_pop) begin
            if (mq.size() == 0) m_unf = 1'b1;
            else void'(mq.pop_back());
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("model_top",   stack_output, (mq.size() != 0) ? mq[mq.size()-1] : 32'h0);
            check("model_count", 32'(stack_count), 32'(mq.size()));
            check("model_empty", 32'(stack_empty), 32'(mq.size() == 0));
            check("model_full",  32'(stack_full),  32'(mq.size() == DEPTH));
            check("model_ovf",   32'(stack_overflow),  32'(m_ovf));
            check("model_unf",   32'(stack_underflow), 32'(m_unf));
        end
    end

    // Drive one cycle of requests at the falling edge; return 2 time units after the rising edge.
    task automatic step(input logic psh, input logic pp, input logic clr, input logic rst,
                        input term_word_t d);
        @(negedge clock);
        stack_push  = psh;
        stack_pop   = pp;
        stack_clear = clr;
        reset       = rst;
        stack_input = d;
        @(posedge clock);
        #2;
    endtask

    task automatic fill(input int unsigned n, input term_word_t base);
        for (int unsigned k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 1'b0, base + term_word_t'(k));
    endtask

    task automatic expect_cleared(input string tag);
        check({tag, "_count"}, 32'(stack_count), 32'd0);
        check({tag, "_top"},   stack_output, 32'h0);
        check({tag, "_empty"}, 32'(stack_empty), 32'd1);
        check({tag, "_flags"}, {29'd0, stack_full, stack_overflow, stack_underflow}, 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        stack_clear = 1'b0;
        stack_push  = 1'b0;
        stack_pop   = 1'b0;
        stack_input = '0;

        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        expect_cleared("reset");

        // Push three, pop three
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h11);
        check("push1_top", stack_output, 32'h11);
        check("push1_cnt", 32'(stack_count), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h22);
        check("push2_top", stack_output, 32'h22);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h33);
        check("push3_top", stack_output, 32'h33);
        check("push3_cnt", 32'(stack_count), 32'd3);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        check("pop1_top", stack_output, 32'h22);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        check("pop2_top", stack_output, 32'h11);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        expect_cleared("pop3");

        // Fill to full, overflow, then pop
        fill(DEPTH, 32'h100);
        check("full_flag", 32'(stack_full), 32'd1);
        check("full_top",  stack_output, 32'h10F);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD);
        check("ovf_flag", 32'(stack_overflow), 32'd1);
        check("ovf_cnt",  32'(stack_count), 32'd16);
        check("ovf_top",  stack_output, 32'h10F);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        check("afterfull_full", 32'(stack_full), 32'd0);
        check("afterfull_top",  stack_output, 32'h10E);
        check("ovf_sticky",     32'(stack_overflow), 32'd1);

        // Replace-top with count 2, then while full
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h11);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h22);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'hAA);
        check("repl_cnt", 32'(stack_count), 32'd2);
        check("repl_top", stack_output, 32'hAA);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        check("repl_below", stack_output, 32'h11);
        fill(DEPTH - 1, 32'h200);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'hBB);
        check("replfull_ovf", 32'(stack_overflow), 32'd0);
        check("replfull_top", stack_output, 32'hBB);
        check("replfull_cnt", 32'(stack_count), 32'd16);

        // Underflow, then push+pop on empty
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        check("unf_flag", 32'(stack_underflow), 32'd1);
        check("unf_cnt",  32'(stack_count), 32'd0);
        check("unf_top",  stack_output, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h5);
        check("pp_empty_unf", 32'(stack_underflow), 32'd1);
        check("pp_empty_cnt", 32'(stack_count), 32'd1);
        check("pp_empty_top", stack_output, 32'h5);

        // Clear beats push; reset beats push
        fill(5, 32'h300);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h77);
        expect_cleared("clear");
        fill(5, 32'h400);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h77);
        expect_cleared("rstpush");

        // Randomized phases alternating between push-heavy and pop-heavy traffic
        for (int i = 0; i < 4000; i++) begin
            bit heavy_push;
            heavy_push = ((i / 150) % 2) == 0;
            step($urandom_range(99) < (heavy_push ? 70 : 30),
                 $urandom_range(99) < (heavy_push ? 30 : 70),
                 $urandom_range(199) == 0,
                 $urandom_range(399) == 0,
                 term_word_t'($urandom()));
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clock);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
